seq_divider16: RTL
==================

# seq_divider16

Sequential 16-bit unsigned restoring divider for the lab 3 arithmetic datapath. It sits directly upstream of the 16-bit ripple-borrow subtractor: each cycle it drives the subtractor's A/B operands with the partial remainder and divisor, then consumes the difference and borrow-out to form one quotient bit. A start/done handshake lets a controller issue one division at a time; results hold until the next accepted start.

## Interface
- No parameters; width fixed at 16 to match the subtractor.
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  16  unsigned dividend, captured on accepted start.
- divisor  input  16  unsigned divisor, captured on accepted start.
- busy  output  1  high while iterating (RUN).
- done  output  1  one-cycle pulse; results valid from this cycle on.
- quotient  output  16  unsigned quotient.
- remainder  output  16  unsigned remainder.
- div_by_zero  output  1  set with done when captured divisor was 0; held with results.

## Operation
- Registers: Q (16b, shifts dividend out / quotient in), R (16b partial remainder), Dv (16b divisor), cnt (4b), state.
- States: IDLE, RUN, DONE.
- IDLE: start=1 -> accept. Divisor 0: Q=16'hFFFF, R=dividend, div_by_zero=1, go DONE. Else Q=dividend, R=0, Dv=divisor, cnt=0, div_by_zero=0, go RUN.
- RUN iteration: Rs = {R[14:0], Q[15]}; subtractor gets A=Rs, B=Dv, returns D, Bout. take = R[15] | ~Bout. If take: R=D, Q={Q[14:0],1}; else R=Rs, Q={Q[14:0],0}. cnt increments; iteration with cnt=15 goes DONE.
- R[15]=1 means true 17-bit partial remainder ≥ 2^16 > Dv: subtract unconditionally; D is correct modulo 2^16.
- DONE: done=1 one cycle; next edge -> IDLE unconditionally.
- quotient=Q, remainder=R continuously; meaningful from done until next accepted start (start overwrites Q/R at the accept edge).
- start in RUN or DONE ignored, not queued.
- Unsigned only; no signed mode.

## Timing
- Reset (synchronous): state=IDLE, Q=R=Dv=0, cnt=0, busy=0, done=0, div_by_zero=0, quotient=remainder=0. Reset mid-RUN aborts; no done pulse.
- Start accepted at edge k: busy=1 during cycles after edges k..k+15; done=1, busy=0 in cycle after edge k+16; IDLE after edge k+17. Earliest next accept at edge k+17 (start may be held high; re-accepts then).
- Divide-by-zero accepted at edge k: done=1 in cycle after edge k, busy never asserts; IDLE after edge k+1.
- Subtractor path combinational within one cycle (16-bit ripple); no other combinational input-to-output paths.
- reset and start both high: reset wins.

## Test plan
- 100 / 7: start one cycle -> done exactly 16 cycles after accept edge, quotient=14, remainder=2, div_by_zero=0, busy high exactly 16 cycles.
- 16'hFFFF / 16'hC000 (exercises R[15] path) -> quotient=1, remainder=16'h3FFF; also 16'hFFFF / 1 -> quotient=16'hFFFF, remainder=0.
- 1234 / 0 -> done in cycle after accept, quotient=16'hFFFF, remainder=1234, div_by_zero=1, busy stays 0.
- Start pulsed again mid-RUN with new operands (50/5) during 100/7 -> ignored; results 14/2; then 50/5 accepted in IDLE -> 10/0, div_by_zero=0.
- Reset asserted at iteration 8 of 40000/3 -> next cycle busy=0, done=0, outputs 0; no done pulse; subsequent 40000/3 -> quotient=13333, remainder=1.
- Randomized 1000 pairs vs. reference model (divisor ≠ 0): quotient*divisor+remainder=dividend, remainder<divisor, results stable until next start.

Source files
------------

// File: rtl/seq_divider16.sv
// seq_divider16: 16-bit unsigned restoring divider, one quotient bit per cycle.
// A start/done handshake issues one division at a time; results hold until the next accepted start.
module seq_divider16 (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [15:0] i_dividend,
    input  logic [15:0] i_divisor,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_quotient,
    output logic [15:0] o_remainder,
    output logic        o_div_by_zero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_q;
    logic [15:0] r_r;
    logic [15:0] r_dv;
    logic [3:0]  r_cnt;
    logic        r_dbz;
    logic [15:0] w_q_nxt;
    logic [15:0] w_r_nxt;
    logic [15:0] w_dv_nxt;
    logic [3:0]  w_cnt_nxt;
    logic        w_dbz_nxt;
    logic [15:0] w_rs;
    logic [15:0] w_diff;
    logic        w_bout;
    logic        w_take;

    // 16-bit ripple-borrow subtractor: returns {borrow_out, a - b}
    function automatic logic [16:0] ripple_sub(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] d;
        logic        bw;
        bw = 1'b0;
        for (int i = 0; i < 16; i++) begin
            d[i] = a[i] ^ b[i] ^ bw;
            bw   = (~a[i] & (b[i] | bw)) | (b[i] & bw);
        end
        return {bw, d};
    endfunction

    assign w_rs              = {r_r[14:0], r_q[15]};
    assign {w_bout, w_diff}  = ripple_sub(w_rs, r_dv);
    // A set R[15] means the shifted remainder exceeds 16 bits, so it is always >= divisor
    assign w_take            = r_r[15] | ~w_bout;

    // State and datapath registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_q     <= 16'd0;
            r_r     <= 16'd0;
            r_dv    <= 16'd0;
            r_cnt   <= 4'd0;
            r_dbz   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_r     <= w_r_nxt;
            r_dv    <= w_dv_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dbz   <= w_dbz_nxt;
        end
    end

    // Next-state and datapath update
    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_r_nxt     = r_r;
        w_dv_nxt    = r_dv;
        w_cnt_nxt   = r_cnt;
        w_dbz_nxt   = r_dbz;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_dv_nxt  = i_divisor;
                    w_cnt_nxt = 4'd0;
                    if (i_divisor == 16'd0) begin
                        w_q_nxt     = 16'hFFFF;
                        w_r_nxt     = i_dividend;
                        w_dbz_nxt   = 1'b1;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_q_nxt     = i_dividend;
                        w_r_nxt     = 16'd0;
                        w_dbz_nxt   = 1'b0;
                        w_state_nxt = ST_RUN;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_take) begin
                    w_r_nxt = w_diff;
                    w_q_nxt = {r_q[14:0], 1'b1};
                end else begin
                    w_r_nxt = w_rs;
                    w_q_nxt = {r_q[14:0], 1'b0};
                end
                w_cnt_nxt = r_cnt + 4'd1;
                if (r_cnt == 4'd15) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_busy        = (r_state == ST_RUN);
    assign o_done        = (r_state == ST_DONE);
    assign o_quotient    = r_q;
    assign o_remainder   = r_r;
    assign o_div_by_zero = r_dbz;

endmodule
